// File: rtl/dp_madd_sched.sv
// dp_madd_sched: command scheduler in front of the DP multiply-add engine.
// Commands are buffered in a small FIFO, then each one is run as rep+1 engine
// passes with the split select held stable, and finished with one tagged
// completion. Handshake stalls (no busy after start, or busy too long) abandon
// the command and flag an error in its completion.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready        command push handshake (ready = FIFO not full)
//   i_cmd_idx_split/rep/tag        command payload
//   o_madd_start, o_idx_split      start pulse and split select to the engine
//   i_madd_done                    engine idle indication (low while busy)
//   o_rsp_valid/i_rsp_ready        completion handshake
//   o_rsp_tag, o_rsp_err           completion tag and timeout flag
//   o_busy                         any command queued or in flight
module dp_madd_sched #(
  parameter int TAG_WIDTH   = 4,
  parameter int REP_WIDTH   = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 8,
  parameter int RUN_TIMEOUT = 8191,
  parameter int GAP_CYC     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [1:0]           i_cmd_idx_split,
  input  logic [REP_WIDTH-1:0] i_cmd_rep,
  input  logic [TAG_WIDTH-1:0] i_cmd_tag,
  output logic                 o_madd_start,
  output logic [1:0]           o_idx_split,
  input  logic                 i_madd_done,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [TAG_WIDTH-1:0] o_rsp_tag,
  output logic                 o_rsp_err,
  output logic                 o_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(RUN_TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int ENT_W = 2 + REP_WIDTH + TAG_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GAP       = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t                 state_r, state_next_s;
  logic [ENT_W-1:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]       count_r, count_next_s;
  logic [ENT_W-1:0]       head_s;
  logic                   push_s, pop_s;
  logic [REP_WIDTH-1:0]   rep_cnt_r;
  logic [TAG_WIDTH-1:0]   tag_r;
  logic [WD_W-1:0]        wdog_r;
  logic [GAP_W-1:0]       gap_cnt_r;
  logic                   ack_expired_s, run_expired_s, timeout_s;
  logic                   start_d_s, rsp_valid_d_s, rsp_err_d_s, busy_d_s, ready_d_s;
  logic [TAG_WIDTH-1:0]   rsp_tag_d_s;

  assign head_s        = fifo_mem_r[rd_ptr_r];
  assign push_s        = i_cmd_valid & o_cmd_ready;
  // A command is only taken while the engine reports idle.
  assign pop_s         = (state_r == S_IDLE) && (count_r != CNT_W'(0)) && i_madd_done;
  assign ack_expired_s = (state_r == S_WAIT_ACK) && i_madd_done &&
                         (wdog_r == WD_W'(ACK_TIMEOUT - 1));
  assign run_expired_s = (state_r == S_WAIT_DONE) && !i_madd_done &&
                         (wdog_r == WD_W'(RUN_TIMEOUT - 1));
  assign timeout_s     = ack_expired_s | run_expired_s;

  // FIFO occupancy for the next cycle.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Command FIFO storage, pointers (wrap naturally at power-of-2 depth) and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= {ENT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {i_cmd_idx_split, i_cmd_rep, i_cmd_tag};
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_next_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pop_s) state_next_s = S_GAP;
        else       state_next_s = S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt_r == GAP_W'(GAP_CYC - 1)) state_next_s = S_ISSUE;
        else                                  state_next_s = S_GAP;
      end
      S_ISSUE: state_next_s = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!i_madd_done)       state_next_s = S_WAIT_DONE;
        else if (ack_expired_s) state_next_s = S_RESP;
        else                    state_next_s = S_WAIT_ACK;
      end
      S_WAIT_DONE: begin
        if (i_madd_done) begin
          if (rep_cnt_r == REP_WIDTH'(0)) state_next_s = S_RESP;
          else                            state_next_s = S_GAP;
        end else if (run_expired_s) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_WAIT_DONE;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) state_next_s = S_IDLE;
        else             state_next_s = S_RESP;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Working registers: gap counter, saturating watchdog, pass counter, tag, split.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_r   <= {GAP_W{1'b0}};
      wdog_r      <= {WD_W{1'b0}};
      rep_cnt_r   <= {REP_WIDTH{1'b0}};
      tag_r       <= {TAG_WIDTH{1'b0}};
      o_idx_split <= 2'b00;
    end else begin
      if (state_r == S_GAP) gap_cnt_r <= gap_cnt_r + GAP_W'(1);
      else                  gap_cnt_r <= {GAP_W{1'b0}};

      // Watchdog restarts at issue and again when the engine acknowledges, so
      // the run limit covers only the busy phase of each pass.
      case (state_r)
        S_WAIT_ACK: begin
          if (!i_madd_done)                wdog_r <= {WD_W{1'b0}};
          else if (wdog_r != {WD_W{1'b1}}) wdog_r <= wdog_r + WD_W'(1);
          else                             wdog_r <= wdog_r;
        end
        S_WAIT_DONE: begin
          if (wdog_r != {WD_W{1'b1}}) wdog_r <= wdog_r + WD_W'(1);
          else                        wdog_r <= wdog_r;
        end
        default: wdog_r <= {WD_W{1'b0}};
      endcase

      // Split is only ever loaded at pop, so it stays fixed across all passes.
      if (pop_s) begin
        o_idx_split <= head_s[ENT_W-1 -: 2];
        rep_cnt_r   <= head_s[TAG_WIDTH +: REP_WIDTH];
        tag_r       <= head_s[TAG_WIDTH-1:0];
      end else if ((state_r == S_WAIT_DONE) && i_madd_done && (rep_cnt_r != REP_WIDTH'(0))) begin
        rep_cnt_r <= rep_cnt_r - REP_WIDTH'(1);
      end
    end
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    start_d_s     = (state_next_s == S_ISSUE);
    rsp_valid_d_s = (state_next_s == S_RESP);
    busy_d_s      = (count_next_s != CNT_W'(0)) || (state_next_s != S_IDLE);
    ready_d_s     = (count_next_s != CNT_W'(FIFO_DEPTH));
    // Tag/error are captured on entry to RESP and held through backpressure.
    if ((state_r != S_RESP) && (state_next_s == S_RESP)) begin
      rsp_tag_d_s = tag_r;
      rsp_err_d_s = timeout_s;
    end else begin
      rsp_tag_d_s = o_rsp_tag;
      rsp_err_d_s = o_rsp_err;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_madd_start <= 1'b0;
      o_rsp_valid  <= 1'b0;
      o_rsp_tag    <= {TAG_WIDTH{1'b0}};
      o_rsp_err    <= 1'b0;
      o_busy       <= 1'b0;
      o_cmd_ready  <= 1'b1;
    end else begin
      o_madd_start <= start_d_s;
      o_rsp_valid  <= rsp_valid_d_s;
      o_rsp_tag    <= rsp_tag_d_s;
      o_rsp_err    <= rsp_err_d_s;
      o_busy       <= busy_d_s;
      o_cmd_ready  <= ready_d_s;
    end
  end

endmodule

// File: tb/tb_dp_madd_sched.sv
// Self-checking bench for dp_madd_sched. A simple engine model answers start
// pulses; a negedge monitor records start pulses, done rises and accepted
// completions, and each test compares those records with expectations built
// from the command stream it issued.
module tb_dp_madd_sched;
  localparam int TAG_WIDTH = 4, REP_WIDTH = 3, FIFO_DEPTH = 4;
  localparam int ACK_TIMEOUT = 8, RUN_TIMEOUT = 8191, GAP_CYC = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_cmd_valid = 1'b0, o_cmd_ready;
  logic [1:0] i_cmd_idx_split = 2'b00;
  logic [REP_WIDTH-1:0] i_cmd_rep = '0;
  logic [TAG_WIDTH-1:0] i_cmd_tag = '0;
  logic o_madd_start;
  logic [1:0] o_idx_split;
  logic i_madd_done = 1'b1;
  logic o_rsp_valid, i_rsp_ready = 1'b1;
  logic [TAG_WIDTH-1:0] o_rsp_tag;
  logic o_rsp_err, o_busy;

  dp_madd_sched #(.TAG_WIDTH(TAG_WIDTH), .REP_WIDTH(REP_WIDTH), .FIFO_DEPTH(FIFO_DEPTH),
                  .ACK_TIMEOUT(ACK_TIMEOUT), .RUN_TIMEOUT(RUN_TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_idx_split(i_cmd_idx_split), .i_cmd_rep(i_cmd_rep), .i_cmd_tag(i_cmd_tag),
    .o_madd_start(o_madd_start), .o_idx_split(o_idx_split), .i_madd_done(i_madd_done),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_tag(o_rsp_tag),
    .o_rsp_err(o_rsp_err), .o_busy(o_busy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model knobs.
  int busy_len = 5;
  bit eng_noack = 0, eng_hang = 0;
  bit eng_pend = 0;
  int eng_cnt = 0;

  // Engine model: drops done one cycle after a start pulse, stays busy busy_len cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        i_madd_done = 1'b1; eng_pend = 0; eng_cnt = 0;
      end else begin
        if (eng_pend) begin
          eng_pend = 0; i_madd_done = 1'b0; eng_cnt = busy_len;
        end else if (!i_madd_done) begin
          if (eng_cnt > 0) eng_cnt--;
          if (eng_cnt == 0 && !eng_hang) i_madd_done = 1'b1;
        end
        if (o_madd_start && !eng_noack) eng_pend = 1;
      end
    end
  end

  // Monitor records.
  int start_cnt = 0, start_cyc_last = 0, rise_cyc = 0;
  int lat_done = 0, lat_start = 0;
  bit prev_done = 1, prev_rsp = 0;
  int gap_q[$];
  logic [1:0] split_q[$];
  logic [TAG_WIDTH-1:0] rtag_q[$];
  logic rerr_q[$];

  // Observation of DUT outputs away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_madd_start) begin
        start_cnt++;
        gap_q.push_back(cyc - rise_cyc);
        split_q.push_back(o_idx_split);
        start_cyc_last = cyc;
      end
      if (i_madd_done && !prev_done) rise_cyc = cyc;
      if (o_rsp_valid && !prev_rsp) begin
        lat_done  = cyc - rise_cyc;
        lat_start = cyc - start_cyc_last;
      end
      if (o_rsp_valid && i_rsp_ready) begin
        rtag_q.push_back(o_rsp_tag);
        rerr_q.push_back(o_rsp_err);
      end
    end
    prev_done = i_madd_done;
    prev_rsp  = o_rsp_valid;
  end

  // Called at posedge+1; returns at posedge+1 after the command was accepted.
  task automatic push_cmd(input logic [1:0] sp, input logic [REP_WIDTH-1:0] rp,
                          input logic [TAG_WIDTH-1:0] tg);
    int n = 0;
    i_cmd_valid = 1'b1; i_cmd_idx_split = sp; i_cmd_rep = rp; i_cmd_tag = tg;
    @(negedge clk);
    while (!o_cmd_ready && n < 3000) begin @(negedge clk); n++; end
    if (!o_cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: ready=%0b required 1", o_cmd_ready);
    end
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int limit, output bit ok);
    int k = 0;
    while (rtag_q.size() < n && k < limit) begin @(negedge clk); k++; end
    ok = (rtag_q.size() >= n);
    @(posedge clk); #1;
  endtask

  task automatic wait_starts(input int n, input int limit, output bit ok);
    int k = 0;
    while (start_cnt < n && k < limit) begin @(negedge clk); k++; end
    ok = (start_cnt >= n);
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    gap_q.delete(); split_q.delete(); rtag_q.delete(); rerr_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_madd_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0b want 0", o_madd_start); end
    checks++; if (o_idx_split !== 2'd0) begin errors++; $display("FAIL reset_split: got %0d want 0", o_idx_split); end
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", o_rsp_valid); end
    checks++; if (o_rsp_tag !== '0) begin errors++; $display("FAIL reset_rsp_tag: got %0d want 0", o_rsp_tag); end
    checks++; if (o_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %0b want 0", o_rsp_err); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", o_busy); end
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", o_cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int s0 = start_cnt, bad = 0, k = 0;
    clear_q();
    busy_len = 4106;
    push_cmd(2'd2, 3'd0, 4'd5);
    while (rtag_q.size() == 0 && k < 6000) begin
      @(negedge clk); k++;
      if (start_cnt > s0 && o_idx_split !== 2'd2) bad++;
    end
    @(posedge clk); #1;
    checks++; if (rtag_q.size() != 1) begin errors++; $display("FAIL single_rsp_count: got %0d want 1", rtag_q.size()); end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_split_stable: %0d cycles split!=2, want 0", bad); end
    if (rtag_q.size() > 0) begin
      checks++; if (rtag_q[0] !== 4'd5) begin errors++; $display("FAIL single_tag: got %0d want 5", rtag_q[0]); end
      checks++; if (rerr_q[0] !== 1'b0) begin errors++; $display("FAIL single_err: got %0b want 0", rerr_q[0]); end
    end
    checks++; if (lat_done != 1) begin errors++; $display("FAIL single_rsp_latency: got %0d want 1", lat_done); end
  endtask

  task automatic test_repeat();
    logic [1:0] sp = 2'($urandom_range(0, 3));
    logic [TAG_WIDTH-1:0] tg = 4'($urandom);
    int s0 = start_cnt, bad = 0;
    bit ok;
    clear_q();
    busy_len = $urandom_range(3, 20);
    push_cmd(sp, 3'd2, tg);
    wait_rsp(1, 600, ok);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL repeat_rsp_timeout: got none want 1"); end
    checks++; if (start_cnt - s0 != 3) begin errors++; $display("FAIL repeat_starts: got %0d want 3", start_cnt - s0); end
    checks++; if (rtag_q.size() != 1) begin errors++; $display("FAIL repeat_rsp_count: got %0d want 1", rtag_q.size()); end
    for (int i = 0; i < split_q.size(); i++) if (split_q[i] !== sp) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL repeat_split: %0d pulses wrong, want %0d on all", bad, sp); end
    if (gap_q.size() == 3) begin
      checks++; if (gap_q[1] != GAP_CYC + 1) begin errors++; $display("FAIL repeat_gap1: got %0d want %0d", gap_q[1], GAP_CYC + 1); end
      checks++; if (gap_q[2] != GAP_CYC + 1) begin errors++; $display("FAIL repeat_gap2: got %0d want %0d", gap_q[2], GAP_CYC + 1); end
    end
    if (rtag_q.size() > 0) begin
      checks++; if (rtag_q[0] !== tg) begin errors++; $display("FAIL repeat_tag: got %0d want %0d", rtag_q[0], tg); end
    end
  endtask

  task automatic test_back_to_back();
    logic [TAG_WIDTH-1:0] exp_tag[5];
    logic [1:0] exp_split[$];
    int bad_tag = 0, bad_err = 0, bad_split = 0;
    bit ok;
    clear_q();
    busy_len = 40;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] sp = 2'($urandom_range(0, 3));
      logic [REP_WIDTH-1:0] rp = 3'($urandom_range(0, 1));
      exp_tag[i] = 4'(i * 3 + 1);
      for (int p = 0; p <= int'(rp); p++) exp_split.push_back(sp);
      push_cmd(sp, rp, exp_tag[i]);
    end
    @(negedge clk);
    checks++; if (o_cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0b want 0", o_cmd_ready); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %0b want 1", o_busy); end
    @(posedge clk); #1;
    wait_rsp(5, 3000, ok);
    checks++; if (rtag_q.size() != 5) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 5", rtag_q.size()); end
    for (int i = 0; i < 5 && i < rtag_q.size(); i++) begin
      if (rtag_q[i] !== exp_tag[i]) bad_tag++;
      if (rerr_q[i] !== 1'b0) bad_err++;
    end
    checks++; if (bad_tag != 0) begin errors++; $display("FAIL b2b_tag_order: %0d wrong, want 0", bad_tag); end
    checks++; if (bad_err != 0) begin errors++; $display("FAIL b2b_err: %0d set, want 0", bad_err); end
    if (split_q.size() != exp_split.size()) bad_split = 100;
    else for (int i = 0; i < split_q.size(); i++) if (split_q[i] !== exp_split[i]) bad_split++;
    checks++; if (bad_split != 0) begin errors++; $display("FAIL b2b_pass_splits: %0d wrong (got %0d pulses want %0d)", bad_split, split_q.size(), exp_split.size()); end
  endtask

  task automatic test_ack_timeout();
    int s0 = start_cnt, la;
    bit ok;
    clear_q();
    busy_len = 6;
    eng_noack = 1;
    push_cmd(2'd1, 3'd3, 4'd9);
    wait_starts(s0 + 1, 100, ok);
    eng_noack = 0;
    push_cmd(2'd3, 3'd0, 4'd10);
    wait_rsp(1, 200, ok);
    la = lat_start;
    wait_rsp(2, 400, ok);
    checks++; if (rtag_q.size() != 2) begin errors++; $display("FAIL ack_rsp_count: got %0d want 2", rtag_q.size()); end
    if (rtag_q.size() == 2) begin
      checks++; if (rtag_q[0] !== 4'd9 || rerr_q[0] !== 1'b1) begin errors++; $display("FAIL ack_first_rsp: tag %0d err %0b want tag 9 err 1", rtag_q[0], rerr_q[0]); end
      checks++; if (rtag_q[1] !== 4'd10 || rerr_q[1] !== 1'b0) begin errors++; $display("FAIL ack_next_rsp: tag %0d err %0b want tag 10 err 0", rtag_q[1], rerr_q[1]); end
    end
    checks++; if (la < ACK_TIMEOUT || la > ACK_TIMEOUT + 2) begin errors++; $display("FAIL ack_latency: got %0d want %0d..%0d", la, ACK_TIMEOUT, ACK_TIMEOUT + 2); end
    checks++; if (start_cnt - s0 != 2) begin errors++; $display("FAIL ack_starts: got %0d want 2 (remaining passes abandoned)", start_cnt - s0); end
  endtask

  task automatic test_backpressure();
    int s1, k = 0, bad = 0;
    logic [TAG_WIDTH-1:0] t;
    logic e;
    bit ok;
    clear_q();
    busy_len = 5;
    i_rsp_ready = 1'b0;
    push_cmd(2'd0, 3'd0, 4'd12);
    push_cmd(2'd2, 3'd0, 4'd13);
    while (!o_rsp_valid && k < 300) begin @(negedge clk); k++; end
    t = o_rsp_tag; e = o_rsp_err; s1 = start_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!o_rsp_valid || o_rsp_tag !== t || o_rsp_err !== e) bad++;
    end
    checks++; if (t !== 4'd12) begin errors++; $display("FAIL bp_held_tag: got %0d want 12", t); end
    checks++; if (start_cnt != s1) begin errors++; $display("FAIL bp_no_issue: %0d new starts want 0", start_cnt - s1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles want 0", bad); end
    @(posedge clk); #1;
    i_rsp_ready = 1'b1;
    wait_rsp(2, 300, ok);
    checks++; if (start_cnt != s1 + 1) begin errors++; $display("FAIL bp_resume: got %0d starts want %0d", start_cnt - s1, 1); end
    checks++; if (rtag_q.size() != 2 || rtag_q[0] !== 4'd12 || rtag_q[1] !== 4'd13) begin
      errors++; $display("FAIL bp_order: count %0d want 2 with tags 12,13", rtag_q.size());
    end
  endtask

  task automatic test_run_timeout();
    bit ok;
    clear_q();
    busy_len = 2;
    eng_hang = 1;
    push_cmd(2'd1, 3'd1, 4'd7);
    wait_rsp(1, RUN_TIMEOUT + 300, ok);
    eng_hang = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (!ok || rerr_q[0] !== 1'b1 || rtag_q[0] !== 4'd7) begin errors++; $display("FAIL run_timeout_rsp: ok %0b want tag 7 err 1", ok); end
    checks++; if (lat_start < RUN_TIMEOUT || lat_start > RUN_TIMEOUT + 3) begin errors++; $display("FAIL run_timeout_latency: got %0d want %0d..%0d", lat_start, RUN_TIMEOUT, RUN_TIMEOUT + 3); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL run_timeout_idle: busy %0b want 0", o_busy); end
  endtask

  task automatic test_reset_mid();
    int s0 = start_cnt, n0, bad = 0;
    bit ok;
    clear_q();
    busy_len = 200;
    push_cmd(2'd3, 3'd0, 4'd2);
    push_cmd(2'd1, 3'd0, 4'd3);
    wait_starts(s0 + 1, 100, ok);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_madd_start !== 1'b0 || o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_pulses: start %0b rsp %0b want 0 0", o_madd_start, o_rsp_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b want 0", o_busy); end
    checks++; if (o_idx_split !== 2'd0) begin errors++; $display("FAIL rst_mid_split: got %0d want 0", o_idx_split); end
    n0 = rtag_q.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_rsp_valid || o_busy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet: %0d cycles busy/rsp want 0", bad); end
    checks++; if (start_cnt != s0 + 1 || rtag_q.size() != n0) begin errors++; $display("FAIL rst_mid_lost: starts %0d rsps %0d want 1 0", start_cnt - s0, rtag_q.size() - n0); end
    checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_fifo_empty: ready %0b want 1", o_cmd_ready); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_back_to_back();
    test_ack_timeout();
    test_backpressure();
    test_run_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
